// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Converts a 14-bit binary value to four BCD digits and time-multiplexes them
// onto a 4-digit common-anode FND through one shared BCD-to-FND decoder.
// The value is saturated at 9999 and converted with an iterative double-dabble
// FSM (IDLE -> CONV x14 -> UPDATE). A free-running scanner selects one digit
// at a time.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_Load       single-cycle strobe, captures i_Value (honoured in IDLE only)
//   i_Value      14-bit unsigned value to display
//   i_Blank_Zero enables leading-zero blanking of digits 3..1
//   o_Busy       high while a conversion is in progress
//   o_Overflow   last accepted value was above 9999
//   o_Digit_Sel  active-low one-hot digit enable, bit 0 = ones digit
//   o_Value      BCD digit for the decoder
//   o_EN         decoder blank request (1 = blank)
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_Load,
  input  logic [13:0] i_Value,
  input  logic        i_Blank_Zero,
  output logic        o_Busy,
  output logic        o_Overflow,
  output logic [3:0]  o_Digit_Sel,
  output logic [3:0]  o_Value,
  output logic        o_EN
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [13:0]   SAT_VALUE  = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t        state_q;
  logic [13:0]   shift_q;
  logic [15:0]   bcd_q;
  logic [3:0]    cnt_q;
  logic [15:0]   disp_q;
  logic          ovf_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;

  logic [15:0]   bcd_adj_d;
  logic          blank_d;
  logic [3:0]    value_d;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      if (b[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = b[4*n +: 4] + 4'd3;
      end else begin
        r[4*n +: 4] = b[4*n +: 4];
      end
    end
    return r;
  endfunction

  // Correction applied to the accumulator before each shift step.
  always_comb begin
    bcd_adj_d = dd_adjust(bcd_q);
  end

  // Conversion FSM: capture, 14 shift steps, then publish to the display register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      shift_q <= 14'd0;
      bcd_q   <= 16'd0;
      cnt_q   <= 4'd0;
      disp_q  <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Load) begin
            shift_q <= (i_Value > SAT_VALUE) ? SAT_VALUE : i_Value;
            ovf_q   <= (i_Value > SAT_VALUE);
            bcd_q   <= 16'd0;
            cnt_q   <= 4'd0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= {bcd_adj_d[14:0], shift_q[13]};
          shift_q <= {shift_q[12:0], 1'b0};
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          disp_q  <= bcd_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan prescaler and digit index.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Digit mux and leading-zero detection; digit k is blank when it and every
  // higher digit are zero, digit 0 always shows.
  always_comb begin
    value_d = disp_q[3:0];
    blank_d = 1'b0;
    case (idx_q)
      2'd0: begin
        value_d = disp_q[3:0];
        blank_d = 1'b0;
      end
      2'd1: begin
        value_d = disp_q[7:4];
        blank_d = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        value_d = disp_q[11:8];
        blank_d = (disp_q[15:8] == 8'd0);
      end
      2'd3: begin
        value_d = disp_q[15:12];
        blank_d = (disp_q[15:12] == 4'd0);
      end
      default: begin
        value_d = 4'd0;
        blank_d = 1'b0;
      end
    endcase
  end

  assign o_Busy      = (state_q != IDLE);
  assign o_Overflow  = ovf_q;
  assign o_Digit_Sel = ~(4'b0001 << idx_q);
  assign o_Value     = value_d;
  assign o_EN        = i_Blank_Zero & blank_d;

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_Load = 1'b0;
  logic [13:0] i_Value = 14'd0;
  logic        i_Blank_Zero = 1'b0;
  logic        o_Busy, o_Overflow, o_EN;
  logic [3:0]  o_Digit_Sel, o_Value;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // behavioural reference: displayed integer, load timer, overflow, cycle count
  int m_cyc  = 0;
  int m_busy = 0;
  int m_disp = 0;
  int m_pend = 0;
  int m_ovf  = 0;

  fnd_scan_controller #(.SCAN_DIV(SD)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_Load       (i_Load),
    .i_Value      (i_Value),
    .i_Blank_Zero (i_Blank_Zero),
    .o_Busy       (o_Busy),
    .o_Overflow   (o_Overflow),
    .o_Digit_Sel  (o_Digit_Sel),
    .o_Value      (o_Value),
    .o_EN         (o_EN)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // Reference model: a load taken while idle shows up 15 edges later.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      m_cyc = 0; m_busy = 0; m_disp = 0; m_pend = 0; m_ovf = 0;
    end else begin
      m_cyc++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_disp = m_pend;
      end else if (i_Load) begin
        m_pend = (int'(i_Value) > 9999) ? 9999 : int'(i_Value);
        m_ovf  = (int'(i_Value) > 9999) ? 1 : 0;
        m_busy = 15;
      end
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    int mi;
    if (mon_en) begin
      mi = (m_cyc / SD) % 4;
      check("m_sel",  o_Digit_Sel, ~(32'd1 << mi) & 32'hF);
      check("m_val",  o_Value, (m_disp / p10(mi)) % 10);
      check("m_en",   o_EN, (i_Blank_Zero && mi > 0 && m_disp < p10(mi)) ? 1 : 0);
      check("m_busy", o_Busy, (m_busy > 0) ? 1 : 0);
      check("m_ovf",  o_Overflow, m_ovf);
    end
  end

  task automatic load(input int v);
    @(posedge clk); #1;
    i_Load = 1'b1; i_Value = 14'(v);
    @(posedge clk); #1;
    i_Load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", o_Busy, 0);
  endtask

  // Scan one whole frame and compare against a constant expected display.
  task automatic frame_chk(input string tag, input int exp_val, input logic [3:0] exp_blank);
    int idx;
    for (int s = 0; s < 4 * SD; s++) begin
      @(negedge clk);
      case (o_Digit_Sel)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      check({tag, "_sel"}, (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) begin
        check({tag, "_val"}, o_Value, (exp_val / p10(idx)) % 10);
        check({tag, "_en"}, o_EN, exp_blank[idx]);
      end
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_sel", o_Digit_Sel, 4'b1110);
    check("rst_busy", o_Busy, 0);
    @(negedge clk); #2;
    i_reset = 1'b0;

    // conversion and busy length
    i_Blank_Zero = 1'b0;
    load(1234);
    n = 0;
    while (o_Busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_len", n, 15);
    frame_chk("d1234", 1234, 4'b0000);
    check("ovf1234", o_Overflow, 0);

    // blanking
    i_Blank_Zero = 1'b1;
    load(7);    wait_idle(); frame_chk("d7", 7, 4'b1110);
    load(0);    wait_idle(); frame_chk("d0", 0, 4'b1110);
    load(1005); wait_idle(); frame_chk("d1005", 1005, 4'b0000);

    // overflow
    i_Blank_Zero = 1'b0;
    load(12000);
    check("ovf_edge", o_Overflow, 1);
    wait_idle(); frame_chk("d12000", 9999, 4'b0000);
    load(42);
    check("ovf_clr", o_Overflow, 0);
    wait_idle(); frame_chk("d42", 42, 4'b0000);

    // loads during busy (cycle 5 and the UPDATE cycle 15) are dropped
    load(55);
    repeat (4) @(posedge clk);
    #1; i_Load = 1'b1; i_Value = 14'd66;
    @(posedge clk); #1; i_Load = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_c15", o_Busy, 1);
    i_Load = 1'b1; i_Value = 14'd66;
    @(posedge clk); #1; i_Load = 1'b0;
    check("busy_after15", o_Busy, 0);
    frame_chk("drop55", 55, 4'b0000);
    load(66); wait_idle(); frame_chk("d66", 66, 4'b0000);

    // boundaries
    load(9999);  check("ovf9999", o_Overflow, 0);  wait_idle(); frame_chk("d9999", 9999, 4'b0000);
    load(10000); check("ovf10000", o_Overflow, 1); wait_idle(); frame_chk("d10000", 9999, 4'b0000);
    load(16383); check("ovf16383", o_Overflow, 1); wait_idle(); frame_chk("d16383", 9999, 4'b0000);

    // asynchronous reset in the middle of a conversion and a scan
    load(4321);
    repeat (5) @(posedge clk);
    #3; i_reset = 1'b1;
    #1;
    check("arst_busy", o_Busy, 0);
    check("arst_ovf", o_Overflow, 0);
    check("arst_sel", o_Digit_Sel, 4'b1110);
    check("arst_val", o_Value, 0);
    check("arst_en", o_EN, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    i_reset = 1'b0;
    #1;
    check("rel_sel0", o_Digit_Sel, 4'b1110);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      check("rel_sel", o_Digit_Sel, ~(32'd1 << ((k / 4) % 4)) & 32'hF);
    end
    frame_chk("no_partial", 0, 4'b0000);

    // randomized loads, including strobes while busy, and blank toggling
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      i_Load = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: i_Value = 14'($urandom_range(0, 20));
        1: i_Value = 14'($urandom_range(9990, 10010));
        default: i_Value = 14'($urandom_range(0, 16383));
      endcase
      if ($urandom_range(0, 29) == 0) i_Blank_Zero = ~i_Blank_Zero;
    end
    @(posedge clk); #1; i_Load = 1'b0;
    repeat (40) @(posedge clk);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
